// File: rtl/aes_req_scheduler.sv
// Round-robin front end sharing one fixed-latency pipelined AES core.
// Credit-gated issue; in-order result FIFO with registered head.
module aes_req_scheduler #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*128-1:0] req_state,
  input  logic [N_REQ*128-1:0] req_key,
  output logic [127:0]         core_state,
  output logic [127:0]         core_key,
  input  logic [127:0]         core_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [127:0]         resp_data,
  output logic [ID_W-1:0]      resp_id,
  output logic                 idle
);

  localparam int PTR_W =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic             accept;
  logic             can_issue;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] fifo_nxt;

  logic             dl_v  [LATENCY];
  logic [ID_W-1:0]  dl_id [LATENCY];
  logic [ID_W-1:0]  tail_id;

  logic [127:0]     mem    [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W-1:0] wr_nxt;

  assign can_issue =
    ({1'b0, inflight_cnt} + {1'b0, fifo_cnt})
    < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && can_issue && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign accept = found;

  always_comb begin
    req_ready = '0;
    if (found) req_ready[grant] = 1'b1;
  end

  // Bubbles drive zeros so the core sees no stale plaintext.
  assign core_state = found ? req_state[128*grant +: 128] : '0;
  assign core_key   = found ? req_key[128*grant +: 128]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant == ID_W'(N_REQ-1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        dl_v[i]  <= 1'b0;
        dl_id[i] <= '0;
      end
    end else begin
      dl_v[0]  <= accept;
      dl_id[0] <= grant;
      for (int i = 1; i < LATENCY; i++) begin
        dl_v[i]  <= dl_v[i-1];
        dl_id[i] <= dl_id[i-1];
      end
    end
  end

  assign push    = dl_v[LATENCY-1];
  assign tail_id = dl_id[LATENCY-1];
  assign pop     = resp_valid & resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_cnt <= '0;
    end else begin
      unique case ({accept, push})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  always_comb begin
    fifo_nxt = fifo_cnt;
    if (push && !pop)      fifo_nxt = fifo_cnt + 1'b1;
    else if (pop && !push) fifo_nxt = fifo_cnt - 1'b1;
  end

  assign rd_nxt = (rd_ptr == PTR_W'(FIFO_DEPTH-1)) ?
                  '0 : rd_ptr + 1'b1;
  assign wr_nxt = (wr_ptr == PTR_W'(FIFO_DEPTH-1)) ?
                  '0 : wr_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]    <= core_out;
      mem_id[wr_ptr] <= tail_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      fifo_cnt <= fifo_nxt;
      if (pop)  rd_ptr <= rd_nxt;
      if (push) wr_ptr <= wr_nxt;
    end
  end

  // Head register: next entry on pop, or bypass when head slot frees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      resp_valid <= (fifo_nxt != '0);
      if (pop && fifo_cnt > CNT_W'(1)) begin
        resp_data <= mem[rd_nxt];
        resp_id   <= mem_id[rd_nxt];
      end else if (push && (fifo_cnt == '0 || pop)) begin
        resp_data <= core_out;
        resp_id   <= tail_id;
      end
    end
  end

  assign idle = (inflight_cnt == '0) && (fifo_cnt == '0);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && fifo_cnt == CNT_W'(FIFO_DEPTH) && !pop)
  );

endmodule
